// File: rtl/dmem_access_unit.sv
// Load/store sequencer between MEM stage and dataMemory.
// Ports: req_* valid/ready request in, resp_* completion out, mem_* memory port.
module dmem_access_unit #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_byte,
  input  logic                 req_signed,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_WE,
  output logic [WORD_SIZE-1:0] mem_A,
  output logic [WORD_SIZE-1:0] mem_WD,
  input  logic [WORD_SIZE-1:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t state, nxt;

  logic [3:0]           cnt;
  logic                 we_q;
  logic                 byte_q;
  logic                 sgn_q;
  logic [1:0]           lane_q;
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] wd_q;
  logic [WORD_SIZE-1:0] rd_q;
  logic                 err_q;

  logic                 mis;
  logic                 last;
  logic                 accept;
  logic [7:0]           lb;
  logic [WORD_SIZE-1:0] merged;
  logic [WORD_SIZE-1:0] loaded;

  assign mis    = !req_byte && (req_addr[1:0] != 2'b00);
  assign last   = (cnt == 4'(MEM_LAT - 1));
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_WE     = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          if (mis)                    nxt = RESP;
          else if (req_we && !req_byte) nxt = WRITE;
          else                        nxt = READ;
        end
      end
      READ: begin
        mem_A = a_q;
        if (last) nxt = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_WE = 1'b1;
        mem_A  = a_q;
        mem_WD = wd_q;
        nxt    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rd_q;
        resp_err   = err_q;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Lane byte of the returned word, and that word with the store byte spliced in.
  always_comb begin
    lb     = mem_RD[7:0];
    merged = mem_RD;
    unique case (1'b1)
      lane_q == 2'd0: begin
        lb           = mem_RD[7:0];
        merged[7:0]  = wd_q[7:0];
      end
      lane_q == 2'd1: begin
        lb           = mem_RD[15:8];
        merged[15:8] = wd_q[7:0];
      end
      lane_q == 2'd2: begin
        lb            = mem_RD[23:16];
        merged[23:16] = wd_q[7:0];
      end
      lane_q == 2'd3: begin
        lb            = mem_RD[31:24];
        merged[31:24] = wd_q[7:0];
      end
      default: ;
    endcase
  end

  assign loaded = byte_q
    ? {{(WORD_SIZE-8){sgn_q & lb[7]}}, lb}
    : mem_RD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      we_q   <= 1'b0;
      byte_q <= 1'b0;
      sgn_q  <= 1'b0;
      lane_q <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      we_q   <= req_we;
      byte_q <= req_byte;
      sgn_q  <= req_signed;
      lane_q <= req_addr[1:0];
      a_q    <= req_addr >> 2;
      wd_q   <= req_wdata;
      rd_q   <= '0;
      err_q  <= mis;
    end else if (state == READ) begin
      if (last) begin
        cnt <= '0;
        if (we_q) wd_q <= merged;
        else      rd_q <= loaded;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed and random requests against a
// word-array reference of memory, checking data, errors, latency and writes.
module tb_dmem_access_unit;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic         req_byte;
  logic         req_signed;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         resp_err;
  logic         mem_WE;
  logic [W-1:0] mem_A;
  logic [W-1:0] mem_WD;
  logic [W-1:0] mem_RD;

  logic         clr;
  logic [31:0]  mem  [256];
  bit   [31:0]  refm [256];

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.WORD_SIZE(W), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_WE     (mem_WE),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_WE) begin
      mem[mem_A[7:0]] <= mem_WD;
    end
  end

  assign mem_RD = mem[mem_A[7:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(
    input  bit        we,
    input  bit        byt,
    input  bit        sgn,
    input  bit [31:0] addr,
    input  bit [31:0] wdata,
    input  bit        hold,
    output bit [31:0] rdata_o,
    output bit        err_o
  );
    bit        mis;
    int        idx;
    int        lane;
    int        exp_lat;
    int        exp_wes;
    bit [31:0] exp_rd;
    bit [31:0] exp_wd;
    bit [7:0]  b;
    int        n;
    int        lat;
    int        wes;
    mis     = !byt && (addr[1:0] != 2'b00);
    idx     = int'(addr >> 2) % 256;
    lane    = int'(addr[1:0]);
    b       = refm[idx][8*lane +: 8];
    exp_rd  = 0;
    exp_wd  = wdata;
    exp_wes = (we && !mis) ? 1 : 0;
    if (mis)            exp_lat = 0;
    else if (we && !byt) exp_lat = 1;
    else if (!we)       exp_lat = LAT;
    else                exp_lat = LAT + 1;
    if (!we && !mis) begin
      if (!byt)     exp_rd = refm[idx];
      else if (sgn) exp_rd = 32'(signed'(b));
      else          exp_rd = {24'd0, b};
    end
    if (we && byt) begin
      exp_wd = refm[idx];
      exp_wd[8*lane +: 8] = wdata[7:0];
    end
    @(negedge clk);
    req_we     = we;
    req_byte   = byt;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid  = 0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_we     = 1'($urandom);
      req_byte   = 1'($urandom);
      req_signed = 1'($urandom);
    end
    lat     = -1;
    wes     = 0;
    rdata_o = '1;
    err_o   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("busy_ready", req_ready, 0);
      if (mem_WE) begin
        wes++;
        chk("wr_addr", mem_A, addr >> 2);
        chk("wr_data", mem_WD, exp_wd);
      end
      if (resp_valid) begin
        lat     = i;
        rdata_o = resp_rdata;
        err_o   = resp_err;
        break;
      end else begin
        chk("quiet_resp", {resp_rdata, resp_err}, 0);
      end
    end
    req_valid = 0;
    chk("latency", lat, exp_lat);
    chk("rdata", rdata_o, exp_rd);
    chk("err", err_o, mis);
    chk("we_cycles", wes, exp_wes);
    if (we && !mis) refm[idx] = exp_wd;
    chk("mem_word", mem[idx], refm[idx]);
  endtask

  initial begin
    bit [31:0] rd;
    bit        er;
    rst        = 1;
    clr        = 1;
    req_valid  = 0;
    req_we     = 0;
    req_byte   = 0;
    req_signed = 0;
    req_addr   = 0;
    req_wdata  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {req_ready, resp_valid, resp_rdata, resp_err,
                     mem_WE, mem_A, mem_WD}, 0);
    @(negedge clk);
    clr = 0;
    rst = 0;
    #1;
    chk("rel_ready", req_ready, 1);

    // reset in the middle of a load
    @(negedge clk);
    req_addr  = 400;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    chk("in_read_a", mem_A, 100);
    rst = 1;
    #1;
    chk("midrst_outs", {req_ready, resp_valid, resp_rdata, resp_err,
                        mem_WE, mem_A, mem_WD}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_noresp", resp_valid, 0);
    end
    rst = 0;
    #1;
    chk("midrst_ready", req_ready, 1);

    do_req(1, 0, 0, 400, 32'hFFFF0000, 0, rd, er);
    do_req(0, 0, 0, 400, 0, 0, rd, er);
    chk("t2_rdata", rd, 32'hFFFF0000);

    do_req(1, 0, 0, 800, 32'h0000FFFF, 0, rd, er);
    do_req(1, 1, 0, 801, 32'h000000AB, 0, rd, er);
    chk("t3_rdata", rd, 0);
    chk("t3_mem", mem[200], 32'h0000ABFF);

    do_req(1, 0, 0, 800, 32'h80000000, 0, rd, er);
    do_req(0, 1, 1, 803, 0, 0, rd, er);
    chk("t4_signed", rd, 32'hFFFFFF80);
    do_req(0, 1, 0, 803, 0, 0, rd, er);
    chk("t4_unsigned", rd, 32'h00000080);

    do_req(0, 0, 0, 402, 0, 0, rd, er);
    chk("t5_err", er, 1);
    chk("t5_mem", mem[100], 32'hFFFF0000);

    do_req(1, 1, 0, 402, 32'h11, 1, rd, er);
    do_req(0, 0, 0, 400, 0, 1, rd, er);
    chk("t6_order", rd, 32'h0011_0000 | 32'hFF000000);
    do_req(1, 0, 0, 401, 32'h5, 1, rd, er);
    chk("t6_err", er, 1);

    for (int k = 0; k < 60; k++) begin
      bit [31:0] a;
      a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
             1'($urandom), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
